// File: rtl/alu_bridge_pkg.sv
// Shared register map, STATUS/CTRL bit positions and the STATUS word packer
// for the Wishbone ALU result bridge.
package alu_bridge_pkg;

   typedef enum logic [1:0] {
      REG_DATA    = 2'd0,
      REG_STATUS  = 2'd1,
      REG_CTRL    = 2'd2,
      REG_PUSHCNT = 2'd3
   } reg_sel_e;

   localparam int ST_EMPTY    = 16;
   localparam int ST_FULL     = 17;
   localparam int ST_OVF      = 18;

   localparam int CTRL_DRAIN  = 0;
   localparam int CTRL_FLUSH  = 1;
   localparam int CTRL_OVFCLR = 2;

   function automatic logic [31:0] status_word(input logic [15:0] count,
                                               input logic empty,
                                               input logic full,
                                               input logic ovf);
      logic [31:0] w;
      w             = {16'd0, count};
      w[ST_EMPTY]   = empty;
      w[ST_FULL]    = full;
      w[ST_OVF]     = ovf;
      return w;
   endfunction

endpackage

// File: rtl/wb_alu_result_bridge_sync_fifo.sv
// Power-of-two synchronous FIFO with flush; head word is presented
// combinationally (no output register).
module sync_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic                     i_flush,
   input  logic [WIDTH-1:0]         i_data,
   output logic [WIDTH-1:0]         o_data,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_full,
   output logic                     o_empty
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wptr;
   logic [PW-1:0]    r_rptr;
   logic [PW:0]      r_count;
   logic             w_wr;
   logic             w_rd;

   // Full is judged on the pre-pop count, so a push while full is refused
   // even if a pop happens on the same edge.
   assign o_full  = (r_count == FULL_CNT);
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_data  = r_mem[r_rptr];
   assign w_wr    = i_push & ~o_full & ~i_flush;
   assign w_rd    = i_pop & ~o_empty;

   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_mem[r_wptr] <= i_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else if (i_flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_wr) begin
            r_wptr <= r_wptr + PW'(1);
         end
         if (w_rd) begin
            r_rptr <= r_rptr + PW'(1);
         end
         case ({w_wr, w_rd})
            2'b10:   r_count <= r_count + (PW+1)'(1);
            2'b01:   r_count <= r_count - (PW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/wb_alu_result_bridge.sv
// Wishbone classic slave that queues ALU results and streams them to the LED
// stage. Define ALU_BRIDGE_PUSHCNT_EN to implement the PUSHCNT register.
module wb_alu_result_bridge
   import alu_bridge_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wb_cyc_i,
   input  logic          wb_stb_i,
   input  logic          wb_we_i,
   input  logic [AW-1:0] wb_adr_i,
   input  logic [31:0]   wb_dat_i,
   input  logic [3:0]    wb_sel_i,
   output logic [31:0]   wb_dat_o,
   output logic          wb_ack_o,
   output logic [31:0]   alu_result_out,
   output logic          alu_valid_out
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic          r_ack;
   logic [31:0]   r_dat;
   logic          r_drain_en;
   logic          r_ovf;
   logic          r_valid;
   logic [31:0]   r_result;

   logic          w_req;
   reg_sel_e      w_sel;
   logic          w_ctrl_wr;
   logic          w_push;
   logic          w_pop;
   logic          w_flush;
   logic          w_full;
   logic          w_empty;
   logic [CW-1:0] w_count;
   logic [31:0]   w_head;
   logic [31:0]   w_rdata;
   logic [31:0]   w_pushcnt;
   logic          w_unused_bits;

   assign w_unused_bits = ^{wb_sel_i, wb_adr_i};

   // Holding stb through the ack cycle must not raise a second request.
   assign w_req     = wb_cyc_i & wb_stb_i & ~r_ack;
   assign w_sel     = reg_sel_e'(wb_adr_i[3:2]);
   assign w_ctrl_wr = w_req & wb_we_i & (w_sel == REG_CTRL);
   assign w_push    = w_req & wb_we_i & (w_sel == REG_DATA);
   assign w_flush   = w_ctrl_wr & wb_dat_i[CTRL_FLUSH];
   assign w_pop     = r_drain_en & ~w_empty;

   sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (32)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (w_flush),
      .i_data  (wb_dat_i),
      .o_data  (w_head),
      .o_count (w_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

`ifdef ALU_BRIDGE_PUSHCNT_EN
   logic [31:0] r_pushcnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pushcnt <= 32'd0;
      end else if (w_push & ~w_full) begin
         r_pushcnt <= r_pushcnt + 32'd1;
      end
   end

   assign w_pushcnt = r_pushcnt;
`else
   assign w_pushcnt = 32'd0;
`endif

   always_comb begin
      w_rdata = 32'd0;
      case (w_sel)
         REG_STATUS:  w_rdata = status_word(16'(w_count), w_empty, w_full, r_ovf);
         REG_CTRL:    w_rdata = {31'd0, r_drain_en};
         REG_PUSHCNT: w_rdata = w_pushcnt;
         default:     w_rdata = 32'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ack      <= 1'b0;
         r_dat      <= 32'd0;
         r_drain_en <= 1'b1;
         r_ovf      <= 1'b0;
      end else begin
         r_ack <= w_req;
         r_dat <= (w_req & ~wb_we_i) ? w_rdata : 32'd0;
         if (w_ctrl_wr) begin
            r_drain_en <= wb_dat_i[CTRL_DRAIN];
         end
         if (w_push & w_full) begin
            r_ovf <= 1'b1;
         end else if (w_ctrl_wr & wb_dat_i[CTRL_OVFCLR]) begin
            r_ovf <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_valid  <= 1'b0;
         r_result <= 32'd0;
      end else begin
         r_valid <= w_pop;
         if (w_pop) begin
            r_result <= w_head;
         end
      end
   end

   assign wb_ack_o       = r_ack;
   assign wb_dat_o       = r_dat;
   assign alu_valid_out  = r_valid;
   assign alu_result_out = r_result;

endmodule
